tcm_dport_bridge: RTL and testbench

//  Data-side bridge between the riscv_core data port (mem_d_*) and a single-port, 1-cycle-read TCM SRAM macro.
//  It holds one request at a time, range-checks the address and issues the SRAM access.
//  It adds WAIT_CYCLES of configurable latency, then returns a tagged ack/error response.

---
 rtl/tcm_dport_bridge.sv | 97 +++++++++
 tb/tb_tcm_dport_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tcm_dport_bridge.sv
// tcm_dport_bridge: single-outstanding bridge from the core data port to a 1-cycle-read TCM SRAM
//  clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//  mem_d_* inputs            core request: address, write data, rd, byte write mask, tag, maintenance bits
//  mem_d_accept_o            high while idle and out of reset; a request is taken on that edge
//  mem_d_ack/error/data_rd/resp_tag_o   one-cycle tagged response
//  sram_en/we/addr/wdata_o   SRAM access, driven only in the access cycle
//  sram_rdata_i              SRAM read data, valid the cycle after sram_en_o
module tcm_dport_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int MEM_BYTES = 65536,
  parameter int WAIT_CYCLES = 0,
  parameter int TAG_W = 11,
  localparam int AW = $clog2(MEM_BYTES) - 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [31:0]      mem_d_data_rd_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic             sram_en_o,
  output logic [3:0]       sram_we_o,
  output logic [AW-1:0]    sram_addr_o,
  output logic [31:0]      sram_wdata_o,
  input  logic [31:0]      sram_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state;
  logic rdy, rd_q, hit_q, req, hit, take, resp;
  logic [3:0] cnt, we_q;
  logic [AW-1:0] addr_q;
  logic [31:0] wdata_q, off;
  logic [TAG_W-1:0] tag_q;
  logic unused;
  assign off = mem_d_addr_i - ADDR_BASE;
  assign hit = (mem_d_addr_i >= ADDR_BASE) && (off < 32'(MEM_BYTES));
  assign req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;
  // rdy keeps accept low during reset even though the state already reads IDLE
  assign mem_d_accept_o = rdy && state == IDLE;
  assign take = req && mem_d_accept_o;
  assign unused = ^{mem_d_cacheable_i, off};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      rdy <= 1'b0;
      cnt <= '0;
      we_q <= '0;
      rd_q <= 1'b0;
      hit_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      tag_q <= '0;
    end else begin
      rdy <= 1'b1;
      case (state)
        IDLE: if (take) begin
          addr_q <= off[AW+1:2];
          wdata_q <= mem_d_data_wr_i;
          we_q <= mem_d_wr_i;
          rd_q <= mem_d_rd_i && !(|mem_d_wr_i);
          hit_q <= hit;
          tag_q <= mem_d_req_tag_i;
          state <= ((|mem_d_wr_i) || mem_d_rd_i) && hit ? ACCESS : RESP;
        end
        ACCESS: begin
          cnt <= 4'(WAIT_CYCLES);
          state <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign resp = state == RESP;
  assign sram_en_o = state == ACCESS;
  assign sram_we_o = sram_en_o ? we_q : 4'h0;
  assign sram_addr_o = addr_q;
  assign sram_wdata_o = wdata_q;
  assign mem_d_ack_o = resp;
  assign mem_d_error_o = resp && !hit_q;
  // read data comes straight from the SRAM: it only becomes valid the cycle after the access
  assign mem_d_data_rd_o = resp && hit_q && rd_q ? sram_rdata_i : 32'h0;
  assign mem_d_resp_tag_o = resp ? tag_q : '0;
endmodule

// File: tb/tb_tcm_dport_bridge.sv
// tb_tcm_dport_bridge: directed checks of the TCM bridge with zero and three wait cycles
module tb_tcm_dport_bridge;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [31:0] addr, wdata;
  logic rd, cache, inv, wb, flush;
  logic [3:0] wr;
  logic [10:0] tag;
  logic acc0, ack0, err0, en0, acc3, ack3, err3, en3;
  logic [31:0] rd0, rd3, wd0, wd3, rdata0, rdata3;
  logic [10:0] tag0, tag3;
  logic [3:0] we0, we3;
  logic [13:0] addr0, addr3;
  logic [31:0] mem0 [0:16383];
  logic [31:0] mem3 [0:16383];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tcm_dport_bridge #(.WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata), .mem_d_rd_i(rd),
    .mem_d_wr_i(wr), .mem_d_cacheable_i(cache), .mem_d_req_tag_i(tag), .mem_d_invalidate_i(inv),
    .mem_d_writeback_i(wb), .mem_d_flush_i(flush), .mem_d_accept_o(acc0), .mem_d_ack_o(ack0),
    .mem_d_error_o(err0), .mem_d_data_rd_o(rd0), .mem_d_resp_tag_o(tag0), .sram_en_o(en0),
    .sram_we_o(we0), .sram_addr_o(addr0), .sram_wdata_o(wd0), .sram_rdata_i(rdata0));
  tcm_dport_bridge #(.WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rst_ni(rst_ni), .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata), .mem_d_rd_i(rd),
    .mem_d_wr_i(wr), .mem_d_cacheable_i(cache), .mem_d_req_tag_i(tag), .mem_d_invalidate_i(inv),
    .mem_d_writeback_i(wb), .mem_d_flush_i(flush), .mem_d_accept_o(acc3), .mem_d_ack_o(ack3),
    .mem_d_error_o(err3), .mem_d_data_rd_o(rd3), .mem_d_resp_tag_o(tag3), .sram_en_o(en3),
    .sram_we_o(we3), .sram_addr_o(addr3), .sram_wdata_o(wd3), .sram_rdata_i(rdata3));
  always @(posedge clk) begin
    if (en0) begin
      for (int b = 0; b < 4; b++) if (we0[b]) mem0[addr0][8*b +: 8] <= wd0[8*b +: 8];
      rdata0 <= mem0[addr0];
    end
    if (en3) begin
      for (int b = 0; b < 4; b++) if (we3[b]) mem3[addr3][8*b +: 8] <= wd3[8*b +: 8];
      rdata3 <= mem3[addr3];
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    rd = 1'b0; wr = 4'h0; inv = 1'b0; wb = 1'b0; flush = 1'b0;
  endtask
  task automatic wait_idle;
    int n = 0;
    while (!(acc0 && acc3) && n < 30) begin
      tick();
      n++;
    end
    chk("idle", 32'({acc0, acc3}), 32'h3);
  endtask
  initial begin
    logic seen;
    idle_in();
    addr = 32'h0; wdata = 32'h0; tag = 11'h0; cache = 1'b0;
    tick(); tick();
    chk("rst_acc0", 32'(acc0), 0);
    chk("rst_acc3", 32'(acc3), 0);
    chk("rst_ack", 32'({ack0, ack3}), 0);
    chk("rst_en", 32'({en0, en3}), 0);
    rst_ni = 1'b1;
    tick();
    chk("rel_acc", 32'({acc0, acc3}), 32'h3);
    // write hit, no wait cycles
    wr = 4'hF; addr = 32'h100; wdata = 32'hDEADBEEF; tag = 11'd5;
    tick();
    idle_in();
    chk("t1_en", 32'(en0), 1);
    chk("t1_we", 32'(we0), 32'hF);
    chk("t1_addr", 32'(addr0), 32'h40);
    chk("t1_wdata", wd0, 32'hDEADBEEF);
    chk("t1_acc", 32'(acc0), 0);
    chk("t1_noack", 32'(ack0), 0);
    tick();
    chk("t1_ack", 32'(ack0), 1);
    chk("t1_tag", 32'(tag0), 5);
    chk("t1_err", 32'(err0), 0);
    chk("t1_en_off", 32'(en0), 0);
    tick();
    chk("t1_acc_back", 32'(acc0), 1);
    chk("t1_ack_off", 32'(ack0), 0);
    wait_idle();
    // read hit, three wait cycles
    rd = 1'b1; addr = 32'h100; tag = 11'd9;
    tick();
    idle_in();
    chk("t2_en", 32'(en3), 1);
    chk("t2_we", 32'(we3), 0);
    chk("t2_addr", 32'(addr3), 32'h40);
    chk("t2_acc", 32'(acc3), 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("t2_wait%0d", i), 32'({acc3, ack3}), 0);
    end
    tick();
    chk("t2_ack", 32'(ack3), 1);
    chk("t2_data", rd3, 32'hDEADBEEF);
    chk("t2_tag", 32'(tag3), 9);
    chk("t2_err", 32'(err3), 0);
    chk("t2_acc", 32'(acc3), 0);
    tick();
    chk("t2_acc_back", 32'(acc3), 1);
    chk("t2_data_off", rd3, 0);
    wait_idle();
    // out-of-range read
    rd = 1'b1; addr = 32'h0001_0000; tag = 11'd3;
    tick();
    idle_in();
    chk("t3_ack", 32'(ack3), 1);
    chk("t3_err", 32'(err3), 1);
    chk("t3_data", rd3, 0);
    chk("t3_en", 32'(en3), 0);
    chk("t3_tag", 32'(tag3), 3);
    tick();
    chk("t3_acc", 32'(acc3), 1);
    wait_idle();
    // flush completes locally
    flush = 1'b1; addr = 32'h0; tag = 11'h7FF;
    tick();
    idle_in();
    chk("t4_ack", 32'(ack0), 1);
    chk("t4_err", 32'(err0), 0);
    chk("t4_tag", 32'(tag0), 32'h7FF);
    chk("t4_en", 32'(en0), 0);
    wait_idle();
    // rd with wr mask is a write
    rd = 1'b1; wr = 4'h3; addr = 32'h104; wdata = 32'h11223344; tag = 11'd1;
    tick();
    idle_in();
    chk("t4_wen", 32'(en0), 1);
    chk("t4_wwe", 32'(we0), 32'h3);
    chk("t4_waddr", 32'(addr0), 32'h41);
    tick();
    chk("t4_wack", 32'(ack0), 1);
    chk("t4_wdata", rd0, 0);
    chk("t4_wtag", 32'(tag0), 1);
    wait_idle();
    // back-to-back reads held high
    rd = 1'b1; addr = 32'h100; tag = 11'd1;
    chk("t5_acc_c0", 32'(acc0), 1);
    tick();
    tag = 11'd2;
    chk("t5_acc_c1", 32'(acc0), 0);
    tick();
    chk("t5_acc_c2", 32'(acc0), 0);
    chk("t5_ack1", 32'(ack0), 1);
    chk("t5_tag1", 32'(tag0), 1);
    chk("t5_data1", rd0, 32'hDEADBEEF);
    tick();
    chk("t5_acc_c3", 32'(acc0), 1);
    tick();
    idle_in();
    chk("t5_acc_c4", 32'(acc0), 0);
    tick();
    chk("t5_ack2", 32'(ack0), 1);
    chk("t5_tag2", 32'(tag0), 2);
    wait_idle();
    // reset during the wait phase aborts the request
    rd = 1'b1; addr = 32'h100; tag = 11'd4;
    tick();
    idle_in();
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    chk("t6_acc", 32'({acc0, acc3}), 0);
    chk("t6_en", 32'(en3), 0);
    chk("t6_ack", 32'(ack3), 0);
    chk("t6_tag", 32'(tag3), 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    chk("t6_acc_back", 32'(acc3), 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= ack3;
      tick();
    end
    chk("t6_noack", 32'(seen), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
